// File: rtl/pwl_slicer_pkg.sv
// Shared types and helpers for the PWL slicer array.
// Analog levels are signed fixed-point with 1 LSB = 1 mV; the most negative
// code is reserved as the non-finite (NaN) marker and propagates through
// the arithmetic helpers.
`ifndef PWL_TIMEUNIT
`define PWL_TIMEUNIT timeunit 1ns; timeprecision 1ps;
`endif

package pwl_slicer_pkg;
  `PWL_TIMEUNIT

  localparam int PWL_W = 16;
  typedef logic signed [PWL_W-1:0] pwl_t;

  localparam pwl_t PWL_NAN = 16'sh8000;
  localparam pwl_t PWL_MAX = 16'sh7fff;
  localparam pwl_t PWL_MIN = 16'sh8001;

  // Debounce counter width and legal parameter ranges
  localparam int DEB_W     = 4;
  localparam int NCH_MIN   = 1;
  localparam int NCH_MAX   = 32;
  localparam int DEB_MIN   = 1;
  localparam int DEB_MAX   = 15;
  localparam int DEPTH_MAX = 8;

  typedef struct packed {
    logic             raw;
    logic             committed;
    logic [DEB_W-1:0] deb_cnt;
  } ch_state_t;

  localparam ch_state_t CH_STATE_RST = '{raw: 1'b0, committed: 1'b0, deb_cnt: 4'd0};

  function automatic logic pwl_is_nan(input pwl_t v);
    return (v == PWL_NAN);
  endfunction

  // Sample a PWL waveform at the current instant (inputs already carry
  // the present segment value).
  function automatic pwl_t pwl_eval(input pwl_t v);
    return v;
  endfunction

  function automatic pwl_t pwl_neg(input pwl_t v);
    if (pwl_is_nan(v)) begin
      return PWL_NAN;
    end else begin
      return -v;
    end
  endfunction

  // Two-input PWL adder: NaN-propagating, saturating to the finite range
  function automatic pwl_t pwl_add(input pwl_t a, input pwl_t b);
    logic signed [PWL_W:0] sum_s;
    sum_s = {a[PWL_W-1], a} + {b[PWL_W-1], b};
    if (pwl_is_nan(a) || pwl_is_nan(b)) begin
      return PWL_NAN;
    end else if (sum_s > 17'sh07fff) begin
      return PWL_MAX;
    end else if (sum_s < 17'sh18001) begin
      return PWL_MIN;
    end else begin
      return sum_s[PWL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pwl_slicer_ch.sv
// One slicer channel: differential evaluation, hysteresis, debounce and a
// saturating toggle counter of committed-decision flips.
`ifndef PWL_TIMEUNIT
`define PWL_TIMEUNIT timeunit 1ns; timeprecision 1ps;
`endif

module pwl_slicer_ch
  import pwl_slicer_pkg::*;
#(
  parameter int HYST_HALF = 0,
  parameter int DEB       = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  pwl_t             vin,
  input  pwl_t             offset,
  output logic             committed,
  output logic [CNT_W-1:0] tgl_cnt
);
  `PWL_TIMEUNIT

  localparam pwl_t             HH_POS  = pwl_t'(HYST_HALF);
  localparam pwl_t             HH_NEG  = pwl_t'(-HYST_HALF);
  localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEB);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  ch_state_t        st_r;
  ch_state_t        st_n_s;
  pwl_t             d_s;
  logic             raw_s;
  logic             flip_s;
  logic [CNT_W-1:0] tgl_r;

  // Next raw/debounce/committed state from the current differential sample
  always_comb begin
    d_s    = pwl_add(pwl_eval(vin), pwl_neg(pwl_eval(offset)));
    st_n_s = st_r;
    flip_s = 1'b0;
    raw_s  = st_r.raw;
    if (pwl_is_nan(d_s)) begin
      raw_s = st_r.raw;
    end else if (d_s >= HH_POS) begin
      raw_s = 1'b1;
    end else if (d_s <= HH_NEG) begin
      raw_s = 1'b0;
    end else begin
      raw_s = st_r.raw;
    end
    st_n_s.raw = raw_s;
    if (raw_s == st_r.committed) begin
      st_n_s.deb_cnt = 4'd0;
    end else if ((st_r.deb_cnt + 4'd1) >= DEB_LIM) begin
      st_n_s.committed = raw_s;
      st_n_s.deb_cnt   = 4'd0;
      flip_s           = 1'b1;
    end else begin
      st_n_s.deb_cnt = st_r.deb_cnt + 4'd1;
    end
  end

  // Channel state advances only on enabled sampling edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_r <= CH_STATE_RST;
    end else if (en) begin
      st_r <= st_n_s;
    end else begin
      st_r <= st_r;
    end
  end

  // Saturating flip counter; a clear wins over a coincident flip
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tgl_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      tgl_r <= {CNT_W{1'b0}};
    end else if (en && flip_s && (tgl_r != CNT_SAT)) begin
      tgl_r <= tgl_r + CNT_ONE;
    end else begin
      tgl_r <= tgl_r;
    end
  end

  assign committed = st_r.committed;
  assign tgl_cnt   = tgl_r;

endmodule

// File: rtl/pwl_slicer_array.sv
// Array of independent PWL slicer channels with a shared output pipeline
// and a valid flag that tracks how many enabled samples have propagated.
`ifndef PWL_TIMEUNIT
`define PWL_TIMEUNIT timeunit 1ns; timeprecision 1ps;
`endif

module pwl_slicer_array
  import pwl_slicer_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter real HYST  = 0.0,
  parameter int  DEB   = 2,
  parameter int  DEPTH = 2,
  parameter int  CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      clr,
  input  pwl_t [NCH-1:0]            vin,
  input  pwl_t [NCH-1:0]            offset,
  output logic [NCH-1:0]            out,
  output logic                      valid,
  output logic [NCH-1:0][CNT_W-1:0] tgl_cnt
);
  `PWL_TIMEUNIT

  // Half-window in mV, rounded to the nearest code
  localparam int HYST_HALF = $rtoi(HYST * 500.0 + 0.5);
  localparam int DEB_EFF   = (DEB < DEB_MIN) ? DEB_MIN : ((DEB > DEB_MAX) ? DEB_MAX : DEB);
  localparam int DEPTH_EFF = (DEPTH < 0) ? 0 : ((DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH);

  logic [NCH-1:0] committed_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwl_slicer_ch #(
      .HYST_HALF (HYST_HALF),
      .DEB       (DEB_EFF),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .clr       (clr),
      .vin       (vin[i]),
      .offset    (offset[i]),
      .committed (committed_s[i]),
      .tgl_cnt   (tgl_cnt[i])
    );
  end

  if (DEPTH_EFF == 0) begin : g_direct
    logic seen_r;

    // Committed register feeds out directly; valid after the first enabled sample
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        seen_r <= 1'b0;
      end else if (en) begin
        seen_r <= 1'b1;
      end else begin
        seen_r <= seen_r;
      end
    end

    assign out   = committed_s;
    assign valid = seen_r;
  end else begin : g_pipe
    logic [DEPTH_EFF-1:0][NCH-1:0] pipe_r;
    logic [DEPTH_EFF:0]            vld_r;

    // Decision pipeline; frozen while sampling is disabled
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pipe_r <= {(DEPTH_EFF*NCH){1'b0}};
      end else if (en) begin
        pipe_r[0] <= committed_s;
        for (int k = 1; k < DEPTH_EFF; k++) begin
          pipe_r[k] <= pipe_r[k-1];
        end
      end else begin
        pipe_r <= pipe_r;
      end
    end

    // Valid token travels alongside the first committed sample
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_r <= {(DEPTH_EFF+1){1'b0}};
      end else if (en) begin
        vld_r[0] <= 1'b1;
        for (int k = 1; k <= DEPTH_EFF; k++) begin
          vld_r[k] <= vld_r[k-1];
        end
      end else begin
        vld_r <= vld_r;
      end
    end

    assign out   = pipe_r[DEPTH_EFF-1];
    assign valid = vld_r[DEPTH_EFF];
  end

endmodule

// File: doc/pwl_slicer_array.md
PWL_SLICER_ARRAY -- requirements
Module: pwl_slicer_array

Interface
REQ-001 Parameter NCH, default 4: number of independent slicer channels, range 1..32.
REQ-002 Parameter HYST, real, default 0.0: hysteresis window width (V), symmetric about zero.
REQ-003 Parameter DEB, default 2: consecutive agreeing samples required to change a committed decision, range 1..15.
REQ-004 Parameter DEPTH, default 2: output pipeline stages after commit, range 0..8.
REQ-005 Parameter CNT_W, default 8: toggle-counter width per channel.
REQ-006 clk  input  1  sampling clock; decisions taken on rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  sample enable; when low, no sampling and pipeline holds.
REQ-009 clr  input  1  synchronous clear of toggle counters.
REQ-010 vin  input  pwl[NCH]  per-channel analog input.
REQ-011 offset  input  pwl[NCH]  per-channel offset, subtracted from vin.
REQ-012 out  output  NCH  committed, pipelined decisions.
REQ-013 valid  output  1  high when out reflects sampled data.
REQ-014 tgl_cnt  output  NCH x CNT_W  per-channel committed-decision toggle count.

Function
REQ-015 On each rising clk with en=1, each channel SHALL evaluate d = vin - offset at current simulation time using PWL evaluation (no event-driven wakeups).
REQ-016 Raw decision: d >= +HYST/2 -> 1; d <= -HYST/2 -> 0; otherwise previous raw decision held; HYST=0 reduces to d>=0 -> 1.
REQ-017 Debounce: per-channel counter increments while raw differs from committed, resets to 0 when equal; committed flips when counter reaches DEB, counter then resets to 0.
REQ-018 DEB=1 SHALL make committed follow raw with one cycle latency.
REQ-019 Committed decisions SHALL pass through DEPTH register stages; DEPTH=0 drives out directly from committed register.
REQ-020 Total latency from sampling edge to out, with stable input and DEB=1: 1+DEPTH enabled cycles.
REQ-021 valid SHALL rise after 1+DEPTH enabled sampling edges following reset, stay high until reset; en=0 cycles SHALL not count.
REQ-022 When en=0, raw, debounce counters, committed and pipeline SHALL all hold.
REQ-023 tgl_cnt[i] SHALL increment on each committed flip of channel i, saturating at 2^CNT_W-1 (no wrap).
REQ-024 clr=1 SHALL zero all tgl_cnt on that edge; clr coinciding with a flip SHALL yield 0 (clear wins).
REQ-025 Channels SHALL be fully independent; simultaneous flips on all channels SHALL be counted individually.
REQ-026 Non-finite d (NaN) SHALL be treated as inside the hysteresis window (hold).

Reset
REQ-027 rstn=0 SHALL immediately force out=0, valid=0, tgl_cnt=0, raw=0, committed=0, debounce counters=0, pipeline=0, regardless of clk.
REQ-028 Reset asserted mid-debounce or mid-pipeline SHALL discard all in-flight state; first sampling edge after rstn rises is sample 1.
REQ-029 rstn deassertion SHALL take effect at next rising clk; no sampling on the deassertion instant itself.

Structure
REQ-030 Shared package holds: debounce counter width constant (4 bits), channel-state struct (raw, committed, deb_cnt), parameter range limits.
REQ-031 PWL evaluation SHALL use the existing PWL method class; subtraction SHALL reuse the existing two-input PWL adder.
REQ-032 One sub-module pwl_slicer_ch implements a single channel (evaluate, hysteresis, debounce, toggle counter); top generates NCH instances plus shared pipeline/valid logic.
REQ-033 Timeunit and timeprecision SHALL use the codebase timeunit macro.

Verification
REQ-034 NCH=4, HYST=0, DEB=1, DEPTH=2: vin[0] steps 0->0.2 V, offset 0.1 V -> out[0] rises exactly 3 enabled edges later; tgl_cnt[0]=1.
REQ-035 HYST=0.1, DEB=1: ramp d from -0.2 to +0.2 and back -> rise at d>=+0.05, fall at d<=-0.05; no toggle inside +/-0.05.
REQ-036 DEB=3: d alternates sign every edge for 10 edges -> no committed flip, tgl_cnt unchanged; then 3 positive edges -> single flip.
REQ-037 en low for 5 cycles mid-pipeline with input change -> out and valid frozen; resumes with 1+DEPTH enabled-cycle latency.
REQ-038 CNT_W=3: 9 committed flips -> tgl_cnt=7; clr with simultaneous flip -> 0.
REQ-039 rstn pulsed low between clock edges during debounce -> all outputs 0 immediately; valid reasserts after 1+DEPTH enabled edges.
